// File: rtl/bcd_stopwatch_timer.sv
// Prescaled N-digit BCD up/down stopwatch/countdown timer with preset load, lap capture and a done state.
// Registered outputs; done/running decode directly from the state register.
module bcd_stopwatch_timer #(
  parameter int CLOCK_CYCLES = 50_000_000,
  parameter int DIGITS       = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                pause,
  input  logic                clear,
  input  logic                load,
  input  logic [4*DIGITS-1:0] preset,
  input  logic                down,
  input  logic                lap,
  output logic                tick,
  output logic [4*DIGITS-1:0] count,
  output logic [4*DIGITS-1:0] lap_value,
  output logic                done,
  output logic                running
);

  localparam int PW = (CLOCK_CYCLES > 1) ? $clog2(CLOCK_CYCLES) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(CLOCK_CYCLES - 1);
  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] prescaler, prescaler_n;
  logic [W-1:0]  count_n, lap_n;
  logic          tick_n;
  logic [W-1:0]  count_inc, count_dec;
  logic          period_end;

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  assign count_inc  = bcd_inc(count);
  assign count_dec  = bcd_dec(count);
  assign period_end = (prescaler == PS_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      prescaler <= '0;
      count     <= '0;
      lap_value <= '0;
      tick      <= 1'b0;
    end else begin
      state     <= state_n;
      prescaler <= prescaler_n;
      count     <= count_n;
      lap_value <= lap_n;
      tick      <= tick_n;
    end
  end

  always_comb begin
    state_n     = state;
    prescaler_n = prescaler;
    count_n     = count;
    lap_n       = lap_value;
    tick_n      = 1'b0;

    if (clear) begin
      state_n     = IDLE;
      prescaler_n = '0;
      count_n     = '0;
    end else if (load && (state != RUN)) begin
      count_n = bcd_clamp(preset);
      if (state == DONE) state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          prescaler_n = '0;
          if (start && !pause) state_n = RUN;
        end
        RUN: begin
          if (down && (count == '0)) begin
            // Countdown started from zero: finish without stepping.
            state_n     = DONE;
            prescaler_n = '0;
          end else begin
            if (period_end) begin
              prescaler_n = '0;
              tick_n      = 1'b1;
              count_n     = down ? count_dec : count_inc;
            end else begin
              prescaler_n = prescaler + 1'b1;
            end
            if (start && pause) begin
              state_n = PAUSE;
            end else if (!start && !pause) begin
              state_n     = IDLE;
              prescaler_n = '0;
            end
            if (period_end && down && (count_dec == '0)) begin
              state_n     = DONE;
              prescaler_n = '0;
            end
          end
        end
        PAUSE: begin
          if (start && !pause) begin
            state_n = RUN;
          end else if (!start && !pause) begin
            state_n     = IDLE;
            prescaler_n = '0;
          end
        end
        DONE: begin
          count_n     = '0;
          prescaler_n = '0;
          if (!start && !pause) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end

    // Lap sees the pre-step count because it samples the current register.
    if (!clear && lap && ((state == RUN) || (state == PAUSE))) lap_n = count;
  end

  assign done    = (state == DONE);
  assign running = (state == RUN);

endmodule

// File: tb/tb_bcd_stopwatch_timer.sv
// Directed bench: main instance CLOCK_CYCLES=4/DIGITS=2, second instance CLOCK_CYCLES=1/DIGITS=1.
module tb_bcd_stopwatch_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, pause, clear, load, down, lap;
  logic [7:0] preset;
  logic       tick;
  logic [7:0] count, lap_value;
  logic       done, running;

  logic       start_b, pause_b, clear_b, load_b, down_b, lap_b;
  logic [3:0] preset_b;
  logic       tick_b;
  logic [3:0] count_b, lap_value_b;
  logic       done_b, running_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_stopwatch_timer #(.CLOCK_CYCLES(4), .DIGITS(2)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .clear(clear),
    .load(load), .preset(preset), .down(down), .lap(lap),
    .tick(tick), .count(count), .lap_value(lap_value), .done(done), .running(running)
  );

  bcd_stopwatch_timer #(.CLOCK_CYCLES(1), .DIGITS(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .pause(pause_b), .clear(clear_b),
    .load(load_b), .preset(preset_b), .down(down_b), .lap(lap_b),
    .tick(tick_b), .count(count_b), .lap_value(lap_value_b), .done(done_b), .running(running_b)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start = 0; pause = 0; clear = 0; load = 0; down = 0; lap = 0; preset = 8'h00;
    start_b = 0; pause_b = 0; clear_b = 0; load_b = 0; down_b = 0; lap_b = 0; preset_b = 4'h0;

    step(1);
    check("rst_count", count, 8'h00);
    check("rst_lap", lap_value, 8'h00);
    check("rst_tick", tick, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_running", running, 1'b0);

    // Up count: tick every 4th cycle, lap at 09->10, wrap at 99.
    rst = 1'b0; start = 1'b1;
    step(1);
    check("t1_running", running, 1'b1);
    step(3);
    check("t1_no_tick_yet", tick, 1'b0);
    check("t1_count_0", count, 8'h00);
    step(1);
    check("t1_tick1", tick, 1'b1);
    check("t1_count_1", count, 8'h01);
    step(1);
    check("t1_tick_low", tick, 1'b0);
    step(3);
    check("t1_tick2", tick, 1'b1);
    check("t1_count_2", count, 8'h02);
    step(31);
    check("t4_count_09", count, 8'h09);
    lap = 1'b1;
    step(1);
    lap = 1'b0;
    check("t4_count_10", count, 8'h10);
    check("t4_lap_09", lap_value, 8'h09);
    check("t4_tick", tick, 1'b1);
    step(356);
    check("t1_count_99", count, 8'h99);
    step(4);
    check("t1_wrap_00", count, 8'h00);
    check("t1_wrap_tick", tick, 1'b1);
    check("t1_wrap_done", done, 1'b0);

    // Load during RUN ignored, then clear during RUN.
    load = 1'b1; preset = 8'h55;
    step(4);
    check("t5_load_ignored", count, 8'h01);
    check("t5_run_kept", running, 1'b1);
    load = 1'b0;
    clear = 1'b1;
    step(1);
    check("t5_clear_count", count, 8'h00);
    check("t5_clear_idle", running, 1'b0);
    check("t5_clear_tick", tick, 1'b0);
    check("t5_clear_lap", lap_value, 8'h09);
    start = 1'b0;
    clear = 1'b0;
    step(1);
    check("t5_stay_idle", running, 1'b0);

    // Load with clamped digit in IDLE.
    load = 1'b1; preset = 8'h3C;
    step(1);
    check("t5_load_clamp", count, 8'h39);

    // Countdown from 03.
    preset = 8'h03;
    step(1);
    check("t2_load_03", count, 8'h03);
    load = 1'b0; down = 1'b1; start = 1'b1;
    step(1);
    check("t2_running", running, 1'b1);
    step(4);
    check("t2_count_02", count, 8'h02);
    check("t2_tick1", tick, 1'b1);
    step(4);
    check("t2_count_01", count, 8'h01);
    step(4);
    check("t2_count_00", count, 8'h00);
    check("t2_tick3", tick, 1'b1);
    step(1);
    check("t2_done", done, 1'b1);
    check("t2_tick_off", tick, 1'b0);
    check("t2_not_running", running, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("t2_done_no_tick", tick, 1'b0);
    end
    check("t2_done_hold", done, 1'b1);
    check("t2_count_hold", count, 8'h00);
    start = 1'b0;
    step(1);
    check("t2_idle_done", done, 1'b0);
    check("t2_idle_running", running, 1'b0);

    // Pause two cycles into a period; resume ticks two cycles after release.
    down = 1'b0; start = 1'b1;
    step(3);
    check("t3_running", running, 1'b1);
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("t3_pause_no_tick", tick, 1'b0);
    end
    check("t3_paused", running, 1'b0);
    check("t3_frozen", count, 8'h00);
    pause = 1'b0;
    step(1);
    check("t3_resume_run", running, 1'b1);
    check("t3_resume_no_tick", tick, 1'b0);
    step(1);
    check("t3_resume_tick", tick, 1'b1);
    check("t3_resume_count", count, 8'h01);

    // Load 42 and lap in PAUSE, then async reset mid-RUN.
    pause = 1'b1;
    step(1);
    load = 1'b1; preset = 8'h42;
    step(1);
    check("t6_load_pause", count, 8'h42);
    check("t6_still_paused", running, 1'b0);
    load = 1'b0; lap = 1'b1;
    step(1);
    check("t6_lap_pause", lap_value, 8'h42);
    lap = 1'b0; pause = 1'b0;
    step(1);
    check("t6_run_again", running, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("t6_async_count", count, 8'h00);
    check("t6_async_lap", lap_value, 8'h00);
    check("t6_async_tick", tick, 1'b0);
    check("t6_async_done", done, 1'b0);
    check("t6_async_running", running, 1'b0);
    start = 1'b0;
    step(1);
    rst = 1'b0;
    step(3);
    check("t6_post_rst_idle", running, 1'b0);
    check("t6_post_rst_count", count, 8'h00);
    start = 1'b1;
    step(1);
    check("t6_post_rst_start", running, 1'b1);
    start = 1'b0;

    // Zero countdown with a one-cycle prescaler.
    down_b = 1'b1; start_b = 1'b1;
    step(1);
    check("b_running", running_b, 1'b1);
    check("b_no_tick0", tick_b, 1'b0);
    step(1);
    check("b_zero_done", done_b, 1'b1);
    check("b_zero_no_tick", tick_b, 1'b0);
    check("b_zero_count", count_b, 4'h0);
    start_b = 1'b0;
    step(1);
    check("b_idle", done_b, 1'b0);
    down_b = 1'b0; start_b = 1'b1;
    step(1);
    check("b_up_run", running_b, 1'b1);
    step(1);
    check("b_tick_a", tick_b, 1'b1);
    check("b_count_1", count_b, 4'h1);
    step(1);
    check("b_tick_b", tick_b, 1'b1);
    check("b_count_2", count_b, 4'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
